wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
Parameters:
REQ-001 SHALL have parameter HILO_EN, default 1, meaning HI/LO register path present (0: hi_o/lo_o tie to 0, whilo ignored).

Ports (name  direction  width  meaning):
REQ-002 SHALL have clk  in  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have mem_wreg  in  1  MEM-stage GPR write request.
REQ-005 SHALL have mem_wd  in  5  MEM-stage GPR destination address.
REQ-006 SHALL have mem_wdata  in  32  MEM-stage ALU result.
REQ-007 SHALL have mem_ld  in  1  instruction is a load; result comes from mem_rdata.
REQ-008 SHALL have mem_ld_type  in  3  0=LB, 1=LBU, 2=LH, 3=LHU, 4=LW; others = LW.
REQ-009 SHALL have mem_addr_lo  in  2  byte offset of load address.
REQ-010 SHALL have mem_rdata  in  32  raw big-endian data-memory word.
REQ-011 SHALL have mem_whilo, mem_hi, mem_lo  in  1/32/32  HI/LO write request and values.
REQ-012 SHALL have stall_mem  in  1  MEM stalled, WB not; insert bubble.
REQ-013 SHALL have flush  in  1  pipeline flush; insert bubble.
REQ-014 SHALL have wb_we, wb_waddr, wb_wdata  out  1/5/32  regfile write port.
REQ-015 SHALL have hi_o, lo_o  out  32/32  HI/LO values, WB-bypassed.
REQ-016 SHALL have adel  out  1  misaligned-load exception, one-cycle pulse.

Function
REQ-017 SHALL register MEM-stage inputs into the WB register on every rising edge; wb_* outputs are valid exactly 1 cycle after presentation.
REQ-018 SHALL give update priority rst > flush > stall_mem > capture; flush or stall_mem loads a bubble (we=0, waddr=0, wdata=0, whilo=0, adel=0).
REQ-019 SHALL, for loads, select bytes big-endian: offset 0 -> rdata[31:24], 1 -> [23:16], 2 -> [15:8], 3 -> [7:0]; halfword offset 0 -> [31:16], 2 -> [15:0].
REQ-020 SHALL sign-extend LB/LH and zero-extend LBU/LHU to 32 bits; LW passes the word unchanged.
REQ-021 SHALL flag misalignment when LH/LHU has addr_lo[0]=1 or LW has addr_lo!=0: captured we=0, adel=1 for exactly that one cycle.
REQ-022 SHALL, for non-loads, pass mem_wdata unchanged to wb_wdata.
REQ-023 SHALL drive wb_we=0 whenever the captured address is 0 (r0 never written).
REQ-024 SHALL hold architectural HI/LO registers, written on the edge after the WB register captures whilo=1.
REQ-025 SHALL drive hi_o/lo_o from the WB register's hi/lo when its whilo=1, else from the architectural HI/LO (combinational bypass).
REQ-026 SHALL, with back-to-back whilo writes, make the later instruction's values visible on hi_o/lo_o one cycle after capture with no lost update.

Reset
REQ-027 SHALL, while rst=1 at an edge, clear WB register and HI/LO to 0: wb_we=0, wb_waddr=0, wb_wdata=0, adel=0, hi_o=0, lo_o=0.
REQ-028 SHALL, on rst asserted mid-stream, discard the in-flight instruction; no regfile or HI/LO write occurs from it.

Structure
REQ-029 SHALL place load-type codes (LB..LW) and the data width constant (32) in the shared core package used by decode and MEM.
REQ-030 SHALL implement load alignment/extension as one combinational sub-module, load_align.

Verification
REQ-031 SHALL test: LB, addr_lo=1, rdata=0x12_80_34_56 -> wb_wdata=0xFFFFFF80, wb_we=1 next cycle.
REQ-032 SHALL test: LHU, addr_lo=2, rdata=0x1234_ABCD -> wb_wdata=0x0000ABCD; LW, addr_lo=2 -> wb_we=0, adel=1 for one cycle.
REQ-033 SHALL test: ALU write wd=5, wdata=0xDEADBEEF with flush=1 at the same edge -> wb_we=0, wb_waddr=0; with stall_mem=1 -> bubble; flush and stall_mem together -> bubble.
REQ-034 SHALL test: mem_whilo=1, hi=0xA, lo=0xB -> hi_o/lo_o=0xA/0xB one cycle later (bypass), still 0xA/0xB after bubbles follow.
REQ-035 SHALL test: rst=1 for one edge while WB holds a load to r7 and whilo=1 -> all outputs 0, HI/LO remain 0.
REQ-036 SHALL test: ALU write to wd=0 with wdata=0x1 -> wb_we=0.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// -----------------------------------------------------------------------------
// wb_stage_pkg
// Shared core definitions used by decode, MEM and WB: datapath width,
// register-file address width, load-type encodings and the WB pipeline
// register layout.
// -----------------------------------------------------------------------------
package wb_stage_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;

    // Load-type codes carried down the pipeline from decode.
    // Any code not listed here is treated as a full-word load.
    typedef enum logic [2:0] {
        LD_LB  = 3'd0,
        LD_LBU = 3'd1,
        LD_LH  = 3'd2,
        LD_LHU = 3'd3,
        LD_LW  = 3'd4
    } ld_type_e;

    // Contents of the WB pipeline register. An all-zero value is a bubble.
    typedef struct packed {
        logic                  we;
        logic [REG_ADDR_W-1:0] waddr;
        logic [DATA_W-1:0]     wdata;
        logic                  whilo;
        logic [DATA_W-1:0]     hi;
        logic [DATA_W-1:0]     lo;
        logic                  adel;
    } wb_reg_t;

endpackage

// File: rtl/wb_stage_load_align.sv
// -----------------------------------------------------------------------------
// load_align
// Purely combinational load formatter: picks the addressed byte/halfword out
// of a big-endian memory word, sign- or zero-extends it, and flags accesses
// that are not naturally aligned for their size.
//
// Ports:
//   i_ld_type   in   3   load-type code (ld_type_e; unknown codes act as LW)
//   i_addr_lo   in   2   byte offset within the word
//   i_rdata     in  32   raw big-endian memory word
//   o_data      out 32   extended load result
//   o_misalign  out  1   access is misaligned for its size
// -----------------------------------------------------------------------------
module load_align
    import wb_stage_pkg::*;
(
    input  logic [2:0]        i_ld_type,
    input  logic [1:0]        i_addr_lo,
    input  logic [DATA_W-1:0] i_rdata,
    output logic [DATA_W-1:0] o_data,
    output logic              o_misalign
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Big-endian: offset 0 is the most significant byte.
    always_comb begin
        case (i_addr_lo)
            2'd0:    w_byte = i_rdata[31:24];
            2'd1:    w_byte = i_rdata[23:16];
            2'd2:    w_byte = i_rdata[15:8];
            default: w_byte = i_rdata[7:0];
        endcase
    end

    assign w_half = i_addr_lo[1] ? i_rdata[15:0] : i_rdata[31:16];

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // it unassigned -- otherwise synthesis infers a latch.
        o_data     = i_rdata;
        o_misalign = 1'b0;
        case (i_ld_type)
            LD_LB:  o_data = {{24{w_byte[7]}}, w_byte};
            LD_LBU: o_data = {24'd0, w_byte};
            LD_LH: begin
                o_data     = {{16{w_half[15]}}, w_half};
                o_misalign = i_addr_lo[0];
            end
            LD_LHU: begin
                o_data     = {16'd0, w_half};
                o_misalign = i_addr_lo[0];
            end
            default: o_misalign = (i_addr_lo != 2'd0);
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage
// Write-back pipeline stage. Registers the MEM-stage result (formatting loads
// through load_align), drives the register-file write port, raises a one-cycle
// address-error pulse on misaligned loads, and owns the architectural HI/LO
// registers with a combinational bypass from the WB register.
//
// Parameters:
//   HILO_EN     1: HI/LO path present; 0: hi_o/lo_o are 0 and mem_whilo ignored
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   mem_wreg/mem_wd/mem_wdata      MEM-stage GPR write request/address/result
//   mem_ld/mem_ld_type             load flag and load-type code
//   mem_addr_lo/mem_rdata          load byte offset and raw memory word
//   mem_whilo/mem_hi/mem_lo        HI/LO write request and values
//   stall_mem, flush               both insert a bubble into WB
//   wb_we/wb_waddr/wb_wdata        register-file write port
//   hi_o/lo_o                      HI/LO values, WB-bypassed
//   adel                           misaligned-load exception pulse
// -----------------------------------------------------------------------------
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter bit HILO_EN = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_wreg,
    input  logic [REG_ADDR_W-1:0] mem_wd,
    input  logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_ld,
    input  logic [2:0]            mem_ld_type,
    input  logic [1:0]            mem_addr_lo,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_whilo,
    input  logic [DATA_W-1:0]     mem_hi,
    input  logic [DATA_W-1:0]     mem_lo,
    input  logic                  stall_mem,
    input  logic                  flush,
    output logic                  wb_we,
    output logic [REG_ADDR_W-1:0] wb_waddr,
    output logic [DATA_W-1:0]     wb_wdata,
    output logic [DATA_W-1:0]     hi_o,
    output logic [DATA_W-1:0]     lo_o,
    output logic                  adel
);

    logic [DATA_W-1:0] w_ld_data;
    logic              w_misalign;
    logic              w_adel;
    wb_reg_t           w_next;
    wb_reg_t           r_wb;
    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;

    load_align u_load_align (
        .i_ld_type  (mem_ld_type),
        .i_addr_lo  (mem_addr_lo),
        .i_rdata    (mem_rdata),
        .o_data     (w_ld_data),
        .o_misalign (w_misalign)
    );

    assign w_adel = mem_ld & w_misalign;

    // Value the WB register takes on a normal capture. A misaligned load
    // never writes the register file; r0 is never written.
    always_comb begin
        w_next       = '0;
        w_next.waddr = mem_wd;
        w_next.wdata = mem_ld ? w_ld_data : mem_wdata;
        w_next.we    = mem_wreg & ~w_adel & (mem_wd != '0);
        w_next.adel  = w_adel;
        w_next.whilo = HILO_EN & mem_whilo;
        w_next.hi    = mem_hi;
        w_next.lo    = mem_lo;
    end

    // Priority: reset, then flush/stall bubble, then capture. Because the
    // register reloads every cycle, adel naturally lasts exactly one cycle.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            r_wb <= '0;
        end else if (flush || stall_mem) begin
            r_wb <= '0;
        end else begin
            r_wb <= w_next;
        end
    end

    // Architectural HI/LO commit one edge after WB captures whilo. A reset at
    // that edge wins, so an in-flight HI/LO write is discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (r_wb.whilo) begin
            r_hi <= r_wb.hi;
            r_lo <= r_wb.lo;
        end
    end

    assign wb_we    = r_wb.we;
    assign wb_waddr = r_wb.waddr;
    assign wb_wdata = r_wb.wdata;
    assign adel     = r_wb.adel;

    // Bypass the pending HI/LO write so readers see it before it commits.
    assign hi_o = !HILO_EN ? '0 : (r_wb.whilo ? r_wb.hi : r_hi);
    assign lo_o = !HILO_EN ? '0 : (r_wb.whilo ? r_wb.lo : r_lo);

endmodule

// File: tb/tb_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_wb_stage
// Directed self-checking bench for wb_stage. Each step drives one MEM-stage
// instruction, pushes the expected WB outputs onto a scoreboard queue, and
// after the capturing edge pops and compares them.
// -----------------------------------------------------------------------------
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_wreg;
    logic [4:0]  mem_wd;
    logic [31:0] mem_wdata;
    logic        mem_ld;
    logic [2:0]  mem_ld_type;
    logic [1:0]  mem_addr_lo;
    logic [31:0] mem_rdata;
    logic        mem_whilo;
    logic [31:0] mem_hi;
    logic [31:0] mem_lo;
    logic        stall_mem;
    logic        flush;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        adel;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        adel;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        chk_data;
    } exp_t;

    exp_t sb[$];

    wb_stage #(.HILO_EN(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_wreg   (mem_wreg),
        .mem_wd     (mem_wd),
        .mem_wdata  (mem_wdata),
        .mem_ld     (mem_ld),
        .mem_ld_type(mem_ld_type),
        .mem_addr_lo(mem_addr_lo),
        .mem_rdata  (mem_rdata),
        .mem_whilo  (mem_whilo),
        .mem_hi     (mem_hi),
        .mem_lo     (mem_lo),
        .stall_mem  (stall_mem),
        .flush      (flush),
        .wb_we      (wb_we),
        .wb_waddr   (wb_waddr),
        .wb_wdata   (wb_wdata),
        .hi_o       (hi_o),
        .lo_o       (lo_o),
        .adel       (adel)
    );

    always #5 clk = ~clk;

    task automatic idle();
        rst = 1'b0; mem_wreg = 1'b0; mem_wd = 5'd0; mem_wdata = 32'd0;
        mem_ld = 1'b0; mem_ld_type = 3'd0; mem_addr_lo = 2'd0; mem_rdata = 32'd0;
        mem_whilo = 1'b0; mem_hi = 32'd0; mem_lo = 32'd0;
        stall_mem = 1'b0; flush = 1'b0;
    endtask

    task automatic alu(input logic [4:0] wd, input logic [31:0] data);
        idle();
        mem_wreg = 1'b1; mem_wd = wd; mem_wdata = data;
    endtask

    task automatic load(input logic [2:0] t, input logic [1:0] off,
                        input logic [31:0] rdata, input logic [4:0] wd);
        idle();
        mem_wreg = 1'b1; mem_wd = wd; mem_ld = 1'b1; mem_ld_type = t;
        mem_addr_lo = off; mem_rdata = rdata; mem_wdata = 32'h5A5A_5A5A;
    endtask

    // Push expectation, clock the stimulus in, then pop and compare #1 later.
    task automatic step(input string tag, input logic we, input logic [4:0] wa,
                        input logic [31:0] wd, input logic ad,
                        input logic [31:0] hi, input logic [31:0] lo,
                        input logic chk_data);
        exp_t e;
        e = '{we: we, waddr: wa, wdata: wd, adel: ad, hi: hi, lo: lo, chk_data: chk_data};
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        total++;
        assert (wb_we === e.we) else begin
            bad++; $error("FAIL %s we: got %0b want %0b", tag, wb_we, e.we);
        end
        total++;
        assert (wb_waddr === e.waddr) else begin
            bad++; $error("FAIL %s waddr: got %0d want %0d", tag, wb_waddr, e.waddr);
        end
        if (e.chk_data) begin
            total++;
            assert (wb_wdata === e.wdata) else begin
                bad++; $error("FAIL %s wdata: got %h want %h", tag, wb_wdata, e.wdata);
            end
        end
        total++;
        assert (adel === e.adel) else begin
            bad++; $error("FAIL %s adel: got %0b want %0b", tag, adel, e.adel);
        end
        total++;
        assert (hi_o === e.hi) else begin
            bad++; $error("FAIL %s hi_o: got %h want %h", tag, hi_o, e.hi);
        end
        total++;
        assert (lo_o === e.lo) else begin
            bad++; $error("FAIL %s lo_o: got %h want %h", tag, lo_o, e.lo);
        end
    endtask

    initial begin
        idle();
        #2;

        // Reset
        rst = 1'b1;
        step("reset0", 0, 0, 0, 0, 0, 0, 1);
        step("reset1", 0, 0, 0, 0, 0, 0, 1);

        // Load formatting
        load(3'd0, 2'd1, 32'h1280_3456, 5'd3);
        step("lb_off1", 1, 3, 32'hFFFF_FF80, 0, 0, 0, 1);
        load(3'd1, 2'd1, 32'h1280_3456, 5'd3);
        step("lbu_off1", 1, 3, 32'h0000_0080, 0, 0, 0, 1);
        load(3'd0, 2'd3, 32'h1280_3456, 5'd4);
        step("lb_off3", 1, 4, 32'h0000_0056, 0, 0, 0, 1);
        load(3'd2, 2'd0, 32'h8234_5678, 5'd6);
        step("lh_off0", 1, 6, 32'hFFFF_8234, 0, 0, 0, 1);
        load(3'd3, 2'd2, 32'h1234_ABCD, 5'd7);
        step("lhu_off2", 1, 7, 32'h0000_ABCD, 0, 0, 0, 1);
        load(3'd2, 2'd2, 32'h1234_ABCD, 5'd7);
        step("lh_off2", 1, 7, 32'hFFFF_ABCD, 0, 0, 0, 1);

        // Misalignment: adel for exactly one cycle
        load(3'd4, 2'd2, 32'h1234_ABCD, 5'd8);
        step("lw_misal", 0, 8, 0, 1, 0, 0, 0);
        alu(5'd9, 32'hCAFE_F00D);
        step("adel_clear", 1, 9, 32'hCAFE_F00D, 0, 0, 0, 1);
        load(3'd3, 2'd1, 32'h1234_ABCD, 5'd8);
        step("lhu_misal", 0, 8, 0, 1, 0, 0, 0);
        load(3'd4, 2'd0, 32'h1234_ABCD, 5'd10);
        step("lw_ok", 1, 10, 32'h1234_ABCD, 0, 0, 0, 1);
        load(3'd5, 2'd0, 32'h89AB_CDEF, 5'd11);
        step("other_as_lw", 1, 11, 32'h89AB_CDEF, 0, 0, 0, 1);
        load(3'd6, 2'd1, 32'h89AB_CDEF, 5'd11);
        step("other_misal", 0, 11, 0, 1, 0, 0, 0);

        // r0 is never written
        alu(5'd0, 32'h0000_0001);
        step("r0_alu", 0, 0, 32'h0000_0001, 0, 0, 0, 1);
        load(3'd0, 2'd0, 32'h1280_3456, 5'd0);
        step("r0_load", 0, 0, 32'h0000_0012, 0, 0, 0, 1);

        // Bubbles
        alu(5'd5, 32'hDEAD_BEEF); flush = 1'b1;
        step("flush", 0, 0, 0, 0, 0, 0, 1);
        alu(5'd5, 32'hDEAD_BEEF); stall_mem = 1'b1;
        step("stall", 0, 0, 0, 0, 0, 0, 1);
        alu(5'd5, 32'hDEAD_BEEF); flush = 1'b1; stall_mem = 1'b1;
        step("flush_stall", 0, 0, 0, 0, 0, 0, 1);
        load(3'd4, 2'd1, 32'h1234_ABCD, 5'd8); flush = 1'b1;
        step("flush_misal", 0, 0, 0, 0, 0, 0, 1);
        alu(5'd5, 32'hDEAD_BEEF);
        step("after_bubble", 1, 5, 32'hDEAD_BEEF, 0, 0, 0, 1);

        // HI/LO bypass and commit
        alu(5'd12, 32'd1); mem_whilo = 1'b1; mem_hi = 32'hA; mem_lo = 32'hB;
        step("hilo_bypass", 1, 12, 32'd1, 0, 32'hA, 32'hB, 1);
        idle(); stall_mem = 1'b1;
        step("hilo_commit", 0, 0, 0, 0, 32'hA, 32'hB, 1);
        idle(); flush = 1'b1; mem_whilo = 1'b1; mem_hi = 32'h99; mem_lo = 32'h98;
        step("hilo_flushed", 0, 0, 0, 0, 32'hA, 32'hB, 1);
        idle(); mem_whilo = 1'b1; mem_hi = 32'hC; mem_lo = 32'hD;
        step("hilo_b2b_1", 0, 0, 0, 0, 32'hC, 32'hD, 1);
        idle(); mem_whilo = 1'b1; mem_hi = 32'hE; mem_lo = 32'hF;
        step("hilo_b2b_2", 0, 0, 0, 0, 32'hE, 32'hF, 1);
        idle();
        step("hilo_b2b_hold", 0, 0, 0, 0, 32'hE, 32'hF, 1);

        // Reset mid-stream discards a pending load + HI/LO write
        load(3'd4, 2'd0, 32'h7777_0000, 5'd7);
        mem_whilo = 1'b1; mem_hi = 32'h11; mem_lo = 32'h22;
        step("pre_rst", 1, 7, 32'h7777_0000, 0, 32'h11, 32'h22, 1);
        idle(); rst = 1'b1;
        step("mid_rst", 0, 0, 0, 0, 0, 0, 1);
        idle();
        step("post_rst", 0, 0, 0, 0, 0, 0, 1);

        total++;
        assert (sb.size() == 0) else begin
            bad++; $error("FAIL scoreboard: got %0d left want 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
